mux_4in_1out: RTL and testbench

- 4-to-1 multiplexer for the stimulus/selection datapath.
- Combinational output `out` carries the selected lane of a packed 4-lane input bus.
- A registered copy `out_q` and a registered select `sel_q` serve downstream synchronous logic.
- One clock domain; asynchronous active-low reset clears only the registered state.

---
 rtl/mux_4in_1out.sv | 47 ++++
 tb/tb_mux_4in_1out.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/mux_4in_1out.sv
// mux_4in_1out: 4-lane selector with a combinational output plus registered copies of the lane and the select
// Ports: clk, rst_n (async active-low), in (packed {in3,in2,in1,in0}), select (lane 0..3),
//        en (capture enable), out (combinational lane), out_q (registered lane), sel_q (registered select)
// Optional: define MUX_SEL_CHANGE_EN to add sel_chg, a registered one-cycle pulse on each captured select change
module mux_4in_1out #(
  parameter int DATA_W = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [4*DATA_W-1:0] in,
  input  logic [1:0]          select,
  input  logic                en,
  output logic [DATA_W-1:0]   out,
  output logic [DATA_W-1:0]   out_q,
  output logic [1:0]          sel_q
`ifdef MUX_SEL_CHANGE_EN
  ,
  output logic                sel_chg
`endif
);
  logic [DATA_W-1:0] out_d;
  logic [1:0]        sel_d;
  assign out = in[select*DATA_W +: DATA_W];
  // lane and select come from the same pre-edge values, so out_q always matches lane[sel_q] at capture
  always_comb begin
    out_d = en ? out : out_q;
    sel_d = en ? select : sel_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q <= '0;
      sel_q <= '0;
    end else begin
      out_q <= out_d;
      sel_q <= sel_d;
    end
  end
`ifdef MUX_SEL_CHANGE_EN
  logic sel_chg_d;
  assign sel_chg_d = en && (select != sel_q);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sel_chg <= 1'b0;
    else        sel_chg <= sel_chg_d;
  end
`else
  `endif
endmodule

// File: tb/tb_mux_4in_1out.sv
// tb_mux_4in_1out: randomized scoreboard bench for mux_4in_1out with DATA_W=8
module tb_mux_4in_1out;
  localparam int W = 8;
  typedef logic [3:0][W-1:0] lanes_t;
  typedef struct {
    logic [W-1:0] o;
    logic [W-1:0] oq;
    logic [1:0]   sq;
    logic         chg;
  } exp_t;
  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [4*W-1:0] in_bus = '0;
  logic [1:0]   select = '0;
  logic         en = 1'b0;
  logic [W-1:0] out, out_q;
  logic [1:0]   sel_q;
  logic         sel_chg;
  exp_t         q[$];
  int           n_cmp = 0;
  int           n_fail = 0;
  logic [W-1:0] m_out = '0;
  logic [1:0]   m_sel = '0;
  lanes_t       cur_l = '0;

  mux_4in_1out #(.DATA_W(W)) dut (
    .clk(clk), .rst_n(rst_n), .in(in_bus), .select(select), .en(en),
    .out(out), .out_q(out_q), .sel_q(sel_q)
`ifdef MUX_SEL_CHANGE_EN
    , .sel_chg(sel_chg)
`endif
  );
`ifndef MUX_SEL_CHANGE_EN
  assign sel_chg = 1'b0;
`endif

  always #5 clk = ~clk;

  task automatic check(input string n, input logic [63:0] a, input logic [63:0] e);
    n_cmp++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, a, e, $time);
    end
  endtask

  function automatic lanes_t rnd_lanes();
    lanes_t l;
    for (int k = 0; k < 4; k++) l[k] = W'($urandom);
    return l;
  endfunction

  // drive one cycle of stimulus at the falling edge and record what the next rising edge must produce
  task automatic step(input lanes_t l, input logic [1:0] s, input logic e);
    exp_t x;
    @(negedge clk);
    in_bus = l;
    select = s;
    en = e;
    cur_l = l;
    x.chg = e && (s != m_sel);
    if (e) begin
      m_out = l[s];
      m_sel = s;
    end
    x.o = l[s];
    x.oq = m_out;
    x.sq = m_sel;
    q.push_back(x);
  endtask

  // monitor: one rising edge per queued entry, sampled 1 time unit after the edge
  initial begin
    exp_t x;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() != 0) begin
        x = q.pop_front();
        check("out", 64'(out), 64'(x.o));
        check("out_q", 64'(out_q), 64'(x.oq));
        check("sel_q", 64'(sel_q), 64'(x.sq));
`ifdef MUX_SEL_CHANGE_EN
        check("sel_chg", 64'(sel_chg), 64'(x.chg));
`endif
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    lanes_t l;
    l = '0;
    // combinational tracking for every select while held in reset; registers must stay cleared
    for (int s = 0; s < 4; s++) begin
      select = 2'(s);
      for (int t = 0; t < 8; t++) begin
        l = rnd_lanes();
        in_bus = l;
        #1;
        check("comb_in_reset", 64'(out), 64'(l[s]));
      end
      check("rst_out_q", 64'(out_q), 64'(0));
      check("rst_sel_q", 64'(sel_q), 64'(0));
    end
    @(negedge clk);
    rst_n = 1'b1;
    // directed lane walk
    l = {8'hD3, 8'hC2, 8'hB1, 8'hA0};
    for (int s = 0; s < 4; s++) step(l, 2'(s), 1'b1);
    step(l, 2'd2, 1'b1);
    // asynchronous reset mid-cycle, after the monitor has consumed the capture of C2
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("async_rst_out_q", 64'(out_q), 64'(0));
    check("async_rst_sel_q", 64'(sel_q), 64'(0));
    check("async_rst_out", 64'(out), 64'(cur_l[2]));
    m_out = '0;
    m_sel = '0;
    step(l, 2'd3, 1'b1);
    rst_n = 1'b1;
    // hold with en low while inputs move
    for (int t = 0; t < 5; t++) step(rnd_lanes(), 2'($urandom), 1'b0);
    step(rnd_lanes(), 2'($urandom), 1'b1);
    // select change sequence for the change pulse
    step(l, 2'd0, 1'b1);
    step(l, 2'd0, 1'b1);
    step(l, 2'd1, 1'b1);
    step(l, 2'd1, 1'b1);
    step(l, 2'd3, 1'b1);
    // randomized traffic
    for (int t = 0; t < 300; t++) step(rnd_lanes(), 2'($urandom), ($urandom_range(0, 9) < 7));
    repeat (4) @(posedge clk);
    #2;
    check("queue_drained", 64'(q.size()), 64'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
